// File: rtl/ram_w16b8_host_ctrl_if.sv
// Host command/response port and 16x8 RAM pins for the RAM host controller.
// master = controller side, slave = host plus RAM side.
interface ram_w16b8_host_ctrl_if #(
   parameter int AddressDepth = 4,
   parameter int DataWide     = 8
);
   logic                    req_valid;
   logic                    req_ready;
   logic [1:0]              req_op;
   logic [AddressDepth-1:0] req_addr;
   logic [DataWide-1:0]     req_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [AddressDepth-1:0] rsp_addr;
   logic [DataWide-1:0]     rsp_data;
   logic                    busy;
   logic                    ram_rw;
   logic [3:0]              ram_cs;
   logic [AddressDepth-1:0] ram_addr;
   logic [DataWide-1:0]     ram_din;
   logic [DataWide-1:0]     ram_dout;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready, ram_dout,
      output req_ready, rsp_valid, rsp_addr, rsp_data, busy,
             ram_rw, ram_cs, ram_addr, ram_din
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready, ram_dout,
      input  req_ready, rsp_valid, rsp_addr, rsp_data, busy,
             ram_rw, ram_cs, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_w16b8_host_ctrl.sv
// Host-side initiator for a 16x8 synchronous RAM: write/read/fill/dump commands, registered RAM pins.
// Write 2 cycles, read response 3 cycles after acceptance; responses held until rsp_ready, one command at a time.
module ram_w16b8_host_ctrl #(
   parameter int AddressDepth = 4,
   parameter int DataWide     = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   ram_w16b8_host_ctrl_if.master bus
);
   localparam logic [AddressDepth-1:0] LastAddr = '1;

   typedef enum logic [2:0] {IDLE, WRITE, RD_CMD, RD_WAIT, RSP, FILL} state_t;

   state_t                  r_state, w_nxt_state;
   logic [AddressDepth-1:0] r_addr, w_nxt_addr;
   logic [DataWide-1:0]     r_wdata, w_nxt_wdata;
   logic                    r_dump, w_nxt_dump;
   logic                    w_accept, w_rsp_load, w_rsp_clr, w_ram_sel, w_ram_wr;

   logic                    r_ram_rw;
   logic [3:0]              r_ram_cs;
   logic [AddressDepth-1:0] r_ram_addr;
   logic [DataWide-1:0]     r_ram_din;
   logic                    r_rsp_valid;
   logic [AddressDepth-1:0] r_rsp_addr;
   logic [DataWide-1:0]     r_rsp_data;

   assign bus.req_ready = (r_state == IDLE) & ~i_rst;
   assign w_accept      = bus.req_valid & bus.req_ready;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_addr  = r_addr;
      w_nxt_wdata = r_wdata;
      w_nxt_dump  = r_dump;
      w_rsp_load  = 1'b0;
      w_rsp_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               case (bus.req_op)
                  2'b00: begin
                     w_nxt_state = WRITE;
                     w_nxt_addr  = bus.req_addr;
                     w_nxt_wdata = bus.req_wdata;
                  end
                  2'b01: begin
                     w_nxt_state = RD_CMD;
                     w_nxt_addr  = bus.req_addr;
                     w_nxt_dump  = 1'b0;
                  end
                  2'b10: begin
                     w_nxt_state = FILL;
                     w_nxt_addr  = '0;
                     w_nxt_wdata = bus.req_wdata;
                  end
                  default: begin
                     w_nxt_state = RD_CMD;
                     w_nxt_addr  = '0;
                     w_nxt_dump  = 1'b1;
                  end
               endcase
            end
         end
         WRITE:   w_nxt_state = IDLE;
         RD_CMD:  w_nxt_state = RD_WAIT;
         RD_WAIT: begin
            w_nxt_state = RSP;
            w_rsp_load  = 1'b1;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               w_rsp_clr = 1'b1;
               if (r_dump && (r_addr != LastAddr)) begin
                  w_nxt_state = RD_CMD;
                  w_nxt_addr  = r_addr + AddressDepth'(1);
               end else begin
                  w_nxt_state = IDLE;
               end
            end
         end
         FILL: begin
            // Stop on the last address so the counter never wraps into a 17th write.
            if (r_addr == LastAddr) w_nxt_state = IDLE;
            else                    w_nxt_addr  = r_addr + AddressDepth'(1);
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // RAM pins are registered, so they are derived from the state being entered.
   assign w_ram_sel = (w_nxt_state == WRITE) | (w_nxt_state == RD_CMD) | (w_nxt_state == FILL);
   assign w_ram_wr  = (w_nxt_state == WRITE) | (w_nxt_state == FILL);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_dump      <= 1'b0;
         r_ram_rw    <= 1'b0;
         r_ram_cs    <= 4'h0;
         r_ram_addr  <= '0;
         r_ram_din   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_addr  <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_addr     <= w_nxt_addr;
         r_wdata    <= w_nxt_wdata;
         r_dump     <= w_nxt_dump;
         r_ram_rw   <= w_ram_wr;
         r_ram_cs   <= w_ram_sel ? 4'hF : 4'h0;
         r_ram_addr <= w_nxt_addr;
         r_ram_din  <= w_nxt_wdata;
         if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_data  <= bus.ram_dout;
         end else if (w_rsp_clr) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.busy      = (r_state != IDLE);
   assign bus.ram_rw    = r_ram_rw;
   assign bus.ram_cs    = r_ram_cs;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_din   = r_ram_din;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_addr  = r_rsp_addr;
   assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_ram_w16b8_host_ctrl.sv
// Directed bench for ram_w16b8_host_ctrl with a behavioural 16x8 registered-output RAM.
module tb_ram_w16b8_host_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   wr_count;

   logic [7:0] mem [16];
   logic [7:0] ram_q;
   logic [3:0] got_addr [16];
   logic [7:0] got_data [16];

   ram_w16b8_host_ctrl_if #(.AddressDepth(4), .DataWide(8)) tif ();

   ram_w16b8_host_ctrl #(.AddressDepth(4), .DataWide(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (tif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM: registered Data_Out, tri-stated when deselected
   always @(posedge clk) begin
      if (tif.ram_cs == 4'hF) begin
         if (tif.ram_rw) begin
            mem[tif.ram_addr] <= tif.ram_din;
            wr_count = wr_count + 1;
         end else begin
            ram_q <= mem[tif.ram_addr];
         end
      end else begin
         ram_q <= 'z;
      end
   end
   assign tif.ram_dout = ram_q;

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d, output bit ok);
      int w;
      ok = 1'b0;
      w  = 0;
      @(negedge clk);
      while (!tif.req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (tif.req_ready) begin
         ok = 1'b1;
         tif.req_valid = 1'b1;
         tif.req_op    = op;
         tif.req_addr  = a;
         tif.req_wdata = d;
         @(posedge clk);
         #1;
         tif.req_valid = 1'b0;
         tif.req_op    = 2'($urandom);
         tif.req_addr  = 4'($urandom);
         tif.req_wdata = 8'($urandom);
      end
   endtask

   task automatic do_read(input logic [3:0] a, output logic [3:0] ra, output logic [7:0] rd, output bit ok);
      int w;
      bit sent;
      ok = 1'b0;
      ra = '0;
      rd = '0;
      send_cmd(2'b01, a, 8'h00, sent);
      w = 0;
      @(negedge clk);
      while (sent && !tif.rsp_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (sent && tif.rsp_valid) begin
         ok = 1'b1;
         ra = tif.rsp_addr;
         rd = tif.rsp_data;
         tif.rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         tif.rsp_ready = 1'b0;
      end
   endtask

   task automatic run_dump(output int n);
      bit sent;
      int cyc;
      n = 0;
      cyc = 0;
      send_cmd(2'b11, 4'h0, 8'h00, sent);
      tif.rsp_ready = 1'b1;
      while (sent && n < 16 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (tif.rsp_valid) begin
            got_addr[n] = tif.rsp_addr;
            got_data[n] = tif.rsp_data;
            n++;
         end
      end
      @(posedge clk);
      #1;
      tif.rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] outs;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         outs = {tif.req_ready, tif.busy, tif.rsp_valid, tif.rsp_addr, tif.rsp_data,
                 tif.ram_rw, tif.ram_cs, tif.ram_addr, tif.ram_din};
         checks++;
         if (outs !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs cycle %0d: got %h want 00000000", i, outs);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (tif.req_ready !== 1'b1 || tif.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: ready=%b busy=%b want ready=1 busy=0", tif.req_ready, tif.busy);
      end
   endtask

   task automatic test_write_read;
      bit ok;
      logic [17:0] pins;
      send_cmd(2'b00, 4'd5, 8'hA5, ok);
      @(negedge clk);
      pins = {tif.ram_cs, tif.ram_rw, tif.ram_addr, tif.ram_din, tif.busy};
      checks++;
      if (!ok || pins !== {4'hF, 1'b1, 4'd5, 8'hA5, 1'b1} || tif.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL write_cycle: pins=%h ready=%b want %h ready=0", pins, tif.req_ready,
                  {4'hF, 1'b1, 4'd5, 8'hA5, 1'b1});
      end
      @(negedge clk);
      checks++;
      if (tif.ram_cs !== 4'h0 || tif.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL write_done: cs=%h ready=%b want cs=0 ready=1", tif.ram_cs, tif.req_ready);
      end
      send_cmd(2'b01, 4'd5, 8'h00, ok);
      @(negedge clk);
      checks++;
      if (!ok || tif.ram_cs !== 4'hF || tif.ram_rw !== 1'b0 || tif.ram_addr !== 4'd5 || tif.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL read_cmd: cs=%h rw=%b addr=%0d vld=%b want cs=f rw=0 addr=5 vld=0",
                  tif.ram_cs, tif.ram_rw, tif.ram_addr, tif.rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (tif.ram_cs !== 4'h0 || tif.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL read_wait: cs=%h vld=%b want cs=0 vld=0", tif.ram_cs, tif.rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (tif.rsp_valid !== 1'b1 || tif.rsp_addr !== 4'd5 || tif.rsp_data !== 8'hA5) begin
         failures++;
         $display("FAIL read_rsp: vld=%b addr=%0d data=%h want vld=1 addr=5 data=a5",
                  tif.rsp_valid, tif.rsp_addr, tif.rsp_data);
      end
      tif.rsp_ready = 1'b1;
      @(negedge clk);
      tif.rsp_ready = 1'b0;
      checks++;
      if (tif.rsp_valid !== 1'b0 || tif.busy !== 1'b0) begin
         failures++;
         $display("FAIL read_handshake: vld=%b busy=%b want 0 0", tif.rsp_valid, tif.busy);
      end
   endtask

   task automatic test_fill_dump;
      bit ok;
      int n;
      int wc0;
      logic [16:0] pins;
      logic [16:0] exp_pins;
      logic [3:0]  ia;
      wc0 = wr_count;
      send_cmd(2'b10, 4'd9, 8'h3C, ok);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         ia = 4'(i);
         pins = {tif.ram_cs, tif.ram_rw, tif.ram_addr, tif.ram_din};
         exp_pins = {4'hF, 1'b1, ia, 8'h3C};
         checks++;
         if (!ok || pins !== exp_pins) begin
            failures++;
            $display("FAIL fill_cycle %0d: pins=%h want %h", i, pins, exp_pins);
         end
      end
      @(negedge clk);
      checks++;
      if (tif.ram_cs !== 4'h0 || tif.busy !== 1'b0 || (wr_count - wc0) != 16) begin
         failures++;
         $display("FAIL fill_end: cs=%h busy=%b writes=%0d want cs=0 busy=0 writes=16",
                  tif.ram_cs, tif.busy, wr_count - wc0);
      end
      run_dump(n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL dump_count: got %0d responses want 16", n);
      end
      for (int i = 0; i < n; i++) begin
         ia = 4'(i);
         checks++;
         if (got_addr[i] !== ia || got_data[i] !== 8'h3C) begin
            failures++;
            $display("FAIL dump_word %0d: addr=%0d data=%h want addr=%0d data=3c", i, got_addr[i], got_data[i], i);
         end
      end
   endtask

   task automatic test_dump_stall;
      bit ok;
      bit stalled;
      int n;
      int cyc;
      logic [3:0] ia;
      n = 0;
      cyc = 0;
      stalled = 1'b0;
      send_cmd(2'b11, 4'h0, 8'h00, ok);
      tif.rsp_ready = 1'b1;
      while (ok && n < 16 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (tif.rsp_valid) begin
            if (tif.rsp_addr == 4'd7 && !stalled) begin
               stalled = 1'b1;
               tif.rsp_ready = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  @(negedge clk);
                  checks++;
                  if (tif.rsp_valid !== 1'b1 || tif.rsp_addr !== 4'd7 || tif.rsp_data !== 8'h3C || tif.ram_cs !== 4'h0) begin
                     failures++;
                     $display("FAIL stall_hold %0d: vld=%b addr=%0d data=%h cs=%h want 1 7 3c 0",
                              k, tif.rsp_valid, tif.rsp_addr, tif.rsp_data, tif.ram_cs);
                  end
               end
               tif.rsp_ready = 1'b1;
            end
            got_addr[n] = tif.rsp_addr;
            got_data[n] = tif.rsp_data;
            n++;
         end
      end
      @(posedge clk);
      #1;
      tif.rsp_ready = 1'b0;
      checks++;
      if (!stalled || n != 16) begin
         failures++;
         $display("FAIL stall_dump_count: stalled=%b responses=%0d want 1 16", stalled, n);
      end
      for (int i = 0; i < n; i++) begin
         ia = 4'(i);
         checks++;
         if (got_addr[i] !== ia || got_data[i] !== 8'h3C) begin
            failures++;
            $display("FAIL stall_dump_word %0d: addr=%0d data=%h want addr=%0d data=3c", i, got_addr[i], got_data[i], i);
         end
      end
   endtask

   task automatic test_wrap;
      bit ok0, ok1, ok2, ok3;
      logic [3:0] a15, a0;
      logic [7:0] d15, d0;
      send_cmd(2'b00, 4'd15, 8'h5A, ok0);
      send_cmd(2'b00, 4'd0, 8'hA0, ok1);
      do_read(4'd15, a15, d15, ok2);
      do_read(4'd0, a0, d0, ok3);
      checks++;
      if (!ok0 || !ok1 || !ok2 || a15 !== 4'd15 || d15 !== 8'h5A) begin
         failures++;
         $display("FAIL wrap_read15: ok=%b addr=%0d data=%h want addr=15 data=5a", ok0 & ok1 & ok2, a15, d15);
      end
      checks++;
      if (!ok3 || a0 !== 4'd0 || d0 !== 8'hA0) begin
         failures++;
         $display("FAIL wrap_read0: ok=%b addr=%0d data=%h want addr=0 data=a0", ok3, a0, d0);
      end
   endtask

   task automatic test_reset_mid_fill;
      bit ok;
      bit hit;
      int n;
      int wc0;
      logic [3:0] ia;
      logic [7:0] exp_d;
      hit = 1'b0;
      wc0 = wr_count;
      send_cmd(2'b10, 4'd0, 8'hC3, ok);
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (tif.ram_cs == 4'hF && tif.ram_addr == 4'd8) begin
            hit = 1'b1;
            rst = 1'b1;
         end
      end
      @(negedge clk);
      checks++;
      if (!ok || !hit || tif.ram_cs !== 4'h0 || tif.busy !== 1'b0 || tif.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL midfill_reset: hit=%b cs=%h busy=%b ready=%b want 1 0 0 0", hit, tif.ram_cs, tif.busy, tif.req_ready);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ((wr_count - wc0) != 9 || tif.busy !== 1'b0) begin
         failures++;
         $display("FAIL midfill_writes: writes=%0d busy=%b want 9 0", wr_count - wc0, tif.busy);
      end
      run_dump(n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL midfill_dump_count: got %0d responses want 16", n);
      end
      for (int i = 0; i < n; i++) begin
         ia = 4'(i);
         exp_d = (i < 9) ? 8'hC3 : ((i == 15) ? 8'h5A : 8'h3C);
         checks++;
         if (got_addr[i] !== ia || got_data[i] !== exp_d) begin
            failures++;
            $display("FAIL midfill_word %0d: addr=%0d data=%h want addr=%0d data=%h", i, got_addr[i], got_data[i], i, exp_d);
         end
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      wr_count      = 0;
      rst           = 1'b1;
      tif.req_valid = 1'b0;
      tif.req_op    = 2'b00;
      tif.req_addr  = 4'h0;
      tif.req_wdata = 8'h00;
      tif.rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
      test_reset();
      test_write_read();
      test_fill_dump();
      test_dump_stall();
      test_wrap();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
